// File: rtl/uart_fifo_core.sv
// Full-duplex UART core: oversampling baud divider, TX/RX FIFOs, run-time frame format,
// sticky error capture and internal loopback.
module uart_fifo_core #(
  parameter int unsigned SAMPLING_RATE = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DIV_WIDTH     = 16,
  localparam int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [1:0]           data_bit_num_i,
  input  logic                 stop_bit_num_i,
  input  logic                 parity_en_i,
  input  logic                 parity_type_i,
  input  logic                 tx_en_i,
  input  logic                 rx_en_i,
  input  logic                 loopback_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic [LW-1:0]        tx_level_o,
  output logic [LW-1:0]        rx_level_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 err_clr_i
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned TCW = $clog2(SAMPLING_RATE);
  localparam logic [TCW-1:0] TickLast = TCW'(SAMPLING_RATE - 1);
  localparam logic [TCW-1:0] TickHalf = TCW'(SAMPLING_RATE / 2 - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Baud divider
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 tick;

  always_comb begin
    tick      = (div_cnt_q >= baud_div_i);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
  end

  // Frame format
  logic [2:0] last_data_idx;
  logic [7:0] data_mask;
  assign last_data_idx = {1'b0, data_bit_num_i} + 3'd4;
  assign data_mask     = 8'hFF >> (2'd3 - data_bit_num_i);

  // TX FIFO
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [LW-1:0] tx_wptr_q, tx_rptr_q;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_level_o = tx_wptr_q - tx_rptr_q;
  assign tx_full    = (tx_level_o == LW'(FIFO_DEPTH));
  assign tx_empty   = (tx_level_o == '0);
  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & ~tx_full;
  assign tx_head    = tx_mem_q[tx_rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= tx_data_i;
  end

  // TX FSM
  tx_state_e      tx_state_q, tx_state_d;
  logic [TCW-1:0] tx_tick_q, tx_tick_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_par_q, tx_par_d;
  logic           tx_line, tx_load, tx_bit_end, tx_start_ok;

  assign tx_start_ok = tick & tx_en_i & ~tx_empty;
  assign tx_pop      = tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line    = 1'b1;
    tx_load    = 1'b0;
    tx_bit_end = tick && (tx_tick_q == TickLast);
    if (tx_state_q != TxIdle && tick) tx_tick_d = tx_bit_end ? '0 : tx_tick_q + TCW'(1);
    case (tx_state_q)
      TxIdle: tx_load = tx_start_ok;
      TxStart: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == last_data_idx) begin
            tx_bit_d   = '0;
            tx_state_d = parity_en_i ? TxParity : TxStop;
          end
        end
      end
      TxParity: begin
        tx_line = tx_par_q;
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_bit_d   = '0;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_bit_q[0] == stop_bit_num_i) begin
            tx_state_d = TxIdle;
            // Chain straight into the next frame so back-to-back frames have no gap
            tx_load    = tx_start_ok;
          end else begin
            tx_bit_d = 3'd1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_state_d = TxStart;
      tx_tick_d  = '0;
      tx_shift_d = tx_head & data_mask;
      tx_par_d   = ^(tx_head & data_mask) ^ parity_type_i;
    end
  end

  assign tx_o      = loopback_i ? 1'b1 : tx_line;
  assign tx_busy_o = (tx_state_q != TxIdle);

  // RX input path
  logic rx_meta_q, rx_sync_q, rx_in;
  assign rx_in = loopback_i ? tx_line : rx_sync_q;

  // RX FSM
  rx_state_e      rx_state_q, rx_state_d;
  logic [TCW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_sample, rx_push, par_evt, frm_evt;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    par_evt    = 1'b0;
    frm_evt    = 1'b0;
    rx_sample  = tick && (rx_tick_q == TickLast);
    if (rx_state_q inside {RxData, RxParity, RxStop} && tick) begin
      rx_tick_d = rx_sample ? '0 : rx_tick_q + TCW'(1);
    end
    case (rx_state_q)
      RxIdle: begin
        if (tick && !rx_in) begin
          rx_state_d = RxStart;
          rx_tick_d  = '0;
        end
      end
      RxStart: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + TCW'(1);
          if (rx_tick_q == TickHalf) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_shift_d = '0;
            rx_state_d = rx_in ? RxIdle : RxData;
          end
        end
      end
      RxData: begin
        if (rx_sample) begin
          rx_shift_d[rx_bit_q] = rx_in;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == last_data_idx) begin
            rx_bit_d   = '0;
            rx_state_d = parity_en_i ? RxParity : RxStop;
          end
        end
      end
      RxParity: begin
        if (rx_sample) begin
          par_evt    = (^rx_shift_q) ^ rx_in ^ parity_type_i;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_sample) begin
          frm_evt = ~rx_in;
          if (rx_bit_q[0] == stop_bit_num_i) begin
            rx_push    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_bit_d = 3'd1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
    if (!rx_en_i) begin
      rx_state_d = RxIdle;
      rx_tick_d  = '0;
      rx_push    = 1'b0;
      par_evt    = 1'b0;
      frm_evt    = 1'b0;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [LW-1:0] rx_wptr_q, rx_rptr_q;
  logic          rx_full, rx_pop, rx_push_ok, ovr_evt;

  assign rx_level_o = rx_wptr_q - rx_rptr_q;
  assign rx_full    = (rx_level_o == LW'(FIFO_DEPTH));
  assign rx_valid_o = (rx_level_o != '0);
  assign rx_data_o  = rx_mem_q[rx_rptr_q[AW-1:0]];
  assign rx_pop     = rx_ready_i & rx_valid_o;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands
  assign rx_push_ok = rx_push & (~rx_full | rx_pop);
  assign ovr_evt    = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_shift_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q    <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      tx_state_q   <= TxIdle;
      tx_tick_q    <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tx_wptr_q    <= tx_wptr_q + LW'(tx_push);
      tx_rptr_q    <= tx_rptr_q + LW'(tx_pop);
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_wptr_q    <= rx_wptr_q + LW'(rx_push_ok);
      rx_rptr_q    <= rx_rptr_q + LW'(rx_pop);
      parity_err_o <= (parity_err_o & ~err_clr_i) | par_evt;
      frame_err_o  <= (frame_err_o & ~err_clr_i) | frm_evt;
      overrun_o    <= (overrun_o & ~err_clr_i) | ovr_evt;
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed + randomized bench for uart_fifo_core against a frame-level reference model.
module tb_uart_fifo_core;
  localparam int SR = 16;
  localparam int FD = 16;
  localparam int DW = 16;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] baud_div_i = '0;
  logic [1:0]    data_bit_num_i = 2'b11;
  logic          stop_bit_num_i = 1'b0;
  logic          parity_en_i = 1'b0;
  logic          parity_type_i = 1'b0;
  logic          tx_en_i = 1'b1;
  logic          rx_en_i = 1'b1;
  logic          loopback_i = 1'b0;
  logic [7:0]    tx_data_i = '0;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i = 1'b0;
  logic          rx_i = 1'b1;
  logic          tx_o, tx_busy_o;
  logic [LW-1:0] tx_level_o, rx_level_o;
  logic          parity_err_o, frame_err_o, overrun_o;
  logic          err_clr_i = 1'b0;

  uart_fifo_core #(.SAMPLING_RATE(SR), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .baud_div_i(baud_div_i), .data_bit_num_i(data_bit_num_i),
    .stop_bit_num_i(stop_bit_num_i), .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
    .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .loopback_i(loopback_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_i(rx_i), .tx_o(tx_o),
    .tx_busy_o(tx_busy_o), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_lb = 1'b0;
  int lb_viol = 0;
  always @(negedge clk) if (mon_lb && tx_o !== 1'b1) lb_viol <= lb_viol + 1;

  int errors = 0;
  int checks = 0;

  // Current frame format as the reference model sees it
  int cfg_nb = 8, cfg_sb = 1, cfg_div = 0;
  bit cfg_pen = 1'b0, cfg_pty = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int nb, input bit pen, input bit pty, input int sb, input int dv);
    cfg_nb = nb; cfg_pen = pen; cfg_pty = pty; cfg_sb = sb; cfg_div = dv;
    data_bit_num_i = 2'(nb - 5);
    parity_en_i    = pen;
    parity_type_i  = pty;
    stop_bit_num_i = (sb == 2);
    baud_div_i     = DW'(dv);
  endtask

  function automatic int frame_len();
    return (1 + cfg_nb + int'(cfg_pen) + cfg_sb) * SR * (cfg_div + 1);
  endfunction

  function automatic logic [7:0] dmask();
    return 8'((1 << cfg_nb) - 1);
  endfunction

  // Expected line level for serial bit position idx of a frame carrying d
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    int ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= cfg_nb) return d[idx-1];
    for (int i = 0; i < cfg_nb; i++) ones += int'(d[i]);
    if (cfg_pen && idx == cfg_nb + 1) return 1'((ones % 2) ^ int'(cfg_pty));
    return 1'b1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, output longint t_acc);
    int n = 0;
    @(negedge clk);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && n < 5000) begin @(negedge clk); n++; end
    if (!tx_ready_o) chk("write_timeout", tx_ready_o, 1);
    @(negedge clk);
    tx_valid_i = 1'b0;
    t_acc = cyc;
  endtask

  task automatic push_raw(input logic [7:0] d);
    @(negedge clk);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  task automatic measure_busy(output int dur);
    int n = 0;
    dur = 0;
    while (!tx_busy_o && n < 200) begin @(negedge clk); n++; end
    while (tx_busy_o && dur < 20000) begin @(negedge clk); dur++; end
  endtask

  task automatic wait_rx_valid(input string tag);
    int n = 0;
    while (!rx_valid_o && n < 20000) begin @(negedge clk); n++; end
    if (!rx_valid_o) chk(tag, rx_valid_o, 1);
  endtask

  // Samples each serial bit at 1/4 and 3/4 of its width and compares with the model
  task automatic check_tx_frame(input string tag, input logic [7:0] d, output longint t_fall);
    int bl = SR * (cfg_div + 1);
    int nbits = 1 + cfg_nb + int'(cfg_pen) + cfg_sb;
    int n = 0;
    logic [23:0] obs = '0;
    logic [23:0] exp = '0;
    while (tx_o !== 1'b0 && n < 4 * nbits * bl) begin @(negedge clk); n++; end
    t_fall = cyc;
    if (tx_o !== 1'b0) begin
      chk({tag, "_start_timeout"}, tx_o, 0);
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      repeat (bl / 4) @(negedge clk);
      obs[2*i] = tx_o;
      repeat (bl / 2) @(negedge clk);
      obs[2*i+1] = tx_o;
      exp[2*i]   = exp_bit(d, i);
      exp[2*i+1] = exp_bit(d, i);
      repeat (bl / 4) @(negedge clk);
    end
    chk(tag, obs, exp);
  endtask

  // Drives one frame onto rx_i, optionally with a flipped parity bit or a short low first stop
  task automatic send_serial(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    int bl = SR * (cfg_div + 1);
    int nbits = 1 + cfg_nb + int'(cfg_pen) + cfg_sb;
    logic lvl;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      lvl = exp_bit(d, i);
      if (bad_par && cfg_pen && i == cfg_nb + 1) lvl = ~lvl;
      if (bad_stop && i == cfg_nb + 1 + int'(cfg_pen)) begin
        rx_i = 1'b0;
        repeat (bl / 2 + 4) @(negedge clk);
        rx_i = 1'b1;
        repeat (bl / 2 - 4) @(negedge clk);
      end else begin
        rx_i = lvl;
        repeat (bl) @(negedge clk);
      end
    end
    rx_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_acc, t_fall, t_prev;
    int dur;
    logic [7:0] d;
    logic [7:0] q[$];

    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Reset state
    chk("rst_tx_o", tx_o, 1);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_levels", {tx_level_o, rx_level_o}, 0);
    chk("rst_flags", {parity_err_o, frame_err_o, overrun_o}, 0);

    // Loopback 8N1, div 0
    set_cfg(8, 0, 0, 1, 0);
    loopback_i = 1'b1;
    mon_lb = 1'b1;
    write_byte(8'hA5, t_acc);
    measure_busy(dur);
    chk("lb_busy_len", dur, 160);
    wait_rx_valid("lb_rx_timeout");
    chk("lb_rx_data", rx_data_o, 8'hA5);
    chk("lb_flags", {parity_err_o, frame_err_o, overrun_o}, 0);
    pop_rx();

    // Randomized formats through loopback
    for (int k = 0; k < 6; k++) begin
      set_cfg($urandom_range(5, 8), 1'($urandom), 1'($urandom), $urandom_range(1, 2),
              $urandom_range(0, 2));
      d = 8'($urandom);
      write_byte(d, t_acc);
      measure_busy(dur);
      chk("lb_rand_busy_len", dur, frame_len());
      wait_rx_valid("lb_rand_rx_timeout");
      chk("lb_rand_data", rx_data_o, d & dmask());
      chk("lb_rand_flags", {parity_err_o, frame_err_o, overrun_o}, 0);
      pop_rx();
    end
    mon_lb = 1'b0;
    chk("lb_tx_pin_const", lb_viol, 0);
    loopback_i = 1'b0;

    // 7E2, div 2, with write-to-start latency bound
    set_cfg(7, 1, 0, 2, 2);
    write_byte(8'h7F, t_acc);
    check_tx_frame("tx_7e2", 8'h7F, t_fall);
    chk("tx_7e2_latency", 32'((t_fall - t_acc) <= 4), 1);
    measure_busy(dur);

    // Randomized TX waveforms
    for (int k = 0; k < 3; k++) begin
      set_cfg($urandom_range(5, 8), 1'($urandom), 1'($urandom), $urandom_range(1, 2),
              $urandom_range(0, 1));
      d = 8'($urandom);
      write_byte(d, t_acc);
      check_tx_frame("tx_rand", d, t_fall);
      measure_busy(dur);
    end

    // TX FIFO full, then back-to-back drain
    set_cfg(8, 0, 0, 1, 0);
    tx_en_i = 1'b0;
    q.delete();
    for (int k = 0; k < FD; k++) begin
      d = 8'($urandom);
      q.push_back(d);
      push_raw(d);
    end
    chk("full_ready", tx_ready_o, 0);
    chk("full_level", tx_level_o, FD);
    push_raw(8'hEE);
    chk("full_level_after_extra", tx_level_o, FD);
    tx_en_i = 1'b1;
    t_prev = 0;
    for (int k = 0; k < FD; k++) begin
      check_tx_frame("b2b_frame", q[k], t_fall);
      if (k > 0) chk("b2b_gap", 32'(t_fall - t_prev), 160);
      t_prev = t_fall;
    end
    cycles(300);
    chk("b2b_drained_busy", tx_busy_o, 0);
    chk("b2b_drained_level", tx_level_o, 0);

    // RX overrun through loopback
    loopback_i = 1'b1;
    clr_err();
    q.delete();
    for (int k = 0; k <= FD; k++) begin
      d = 8'($urandom);
      q.push_back(d);
      write_byte(d, t_acc);
    end
    measure_busy(dur);
    for (int n = 0; n < 5000 && (tx_busy_o || tx_level_o != 0); n++) @(negedge clk);
    cycles(20);
    chk("ovr_level", rx_level_o, FD);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_other_flags", {parity_err_o, frame_err_o}, 0);
    for (int k = 0; k < FD; k++) begin
      chk("ovr_order", rx_data_o, q[k]);
      pop_rx();
    end
    chk("ovr_empty", rx_valid_o, 0);
    clr_err();
    chk("ovr_cleared", overrun_o, 0);
    loopback_i = 1'b0;

    // External RX: random good frames
    for (int k = 0; k < 3; k++) begin
      set_cfg($urandom_range(5, 8), 1'($urandom), 1'($urandom), $urandom_range(1, 2),
              $urandom_range(0, 1));
      d = 8'($urandom);
      send_serial(d, 0, 0);
      cycles(20);
      chk("ext_valid", rx_valid_o, 1);
      chk("ext_data", rx_data_o, d & dmask());
      chk("ext_flags", {parity_err_o, frame_err_o}, 0);
      pop_rx();
    end

    // Wrong parity
    set_cfg(8, 1, 0, 1, 0);
    d = 8'($urandom);
    send_serial(d, 1, 0);
    cycles(20);
    chk("par_flag", parity_err_o, 1);
    chk("par_pushed", rx_level_o, 1);
    chk("par_data", rx_data_o, d);
    chk("par_no_frame", frame_err_o, 0);
    pop_rx();
    clr_err();
    chk("par_cleared", parity_err_o, 0);

    // Low stop bit
    d = 8'($urandom);
    send_serial(d, 0, 1);
    cycles(40);
    chk("frm_flag", frame_err_o, 1);
    chk("frm_pushed", rx_level_o, 1);
    chk("frm_data", rx_data_o, d);
    pop_rx();
    clr_err();

    // 3-tick glitch
    @(negedge clk);
    rx_i = 1'b0;
    cycles(3);
    rx_i = 1'b1;
    cycles(40);
    chk("glitch_no_push", rx_level_o, 0);
    chk("glitch_no_flags", {parity_err_o, frame_err_o}, 0);

    // Receiver disabled
    rx_en_i = 1'b0;
    send_serial(8'h5A, 0, 0);
    cycles(20);
    chk("rx_dis_no_push", rx_level_o, 0);
    rx_en_i = 1'b1;

    // Reset mid-frame with both FIFOs holding data
    set_cfg(8, 0, 0, 1, 0);
    send_serial(8'h81, 0, 0);
    cycles(20);
    chk("pre_rst_rx_level", rx_level_o, 1);
    tx_en_i = 1'b0;
    for (int k = 0; k < 3; k++) push_raw(8'($urandom));
    tx_en_i = 1'b1;
    for (int n = 0; n < 100 && !tx_busy_o; n++) @(negedge clk);
    cycles(40);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_tx_o", tx_o, 1);
    chk("rst_mid_busy", tx_busy_o, 0);
    chk("rst_mid_levels", {tx_level_o, rx_level_o}, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    write_byte(8'h3C, t_acc);
    check_tx_frame("post_rst_frame", 8'h3C, t_fall);
    measure_busy(dur);
    chk("post_rst_rx_empty", rx_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
